// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register file write port
// between ALU writeback (req0) and load writeback (req1), with a registered, decoded write port.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REGS-1:0]   wr_onehot,
  output logic                  last_grant,
  output logic [15:0]           conflict_cnt
);

  typedef enum logic {PRI0, PRI1} pri_t;

  pri_t                  state, state_next;
  logic                  grant0, grant1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  both_valid;

  assign both_valid = req0_valid & req1_valid;

  // Grants depend only on valids, stall and priority state, never on request data.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_next = state;
    if (!stall) begin
      if (req0_valid && (!req1_valid || state == PRI0)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
    if (grant0) begin
      state_next = PRI1;
    end else if (grant1) begin
      state_next = PRI0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PRI0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_onehot    <= '0;
      last_grant   <= 1'b1;
      conflict_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (grant0 || grant1) begin
        wr_addr    <= sel_addr;
        wr_data    <= sel_data;
        last_grant <= grant1;
        // Register 0 is hardwired: the transfer completes but nothing is written.
        if (sel_addr != '0) begin
          wr_en     <= 1'b1;
          wr_onehot <= {{(NUM_REGS-1){1'b0}}, 1'b1} << sel_addr;
        end else begin
          wr_en     <= 1'b0;
          wr_onehot <= '0;
        end
      end else begin
        wr_en     <= 1'b0;
        wr_onehot <= '0;
      end
      if (!stall && both_valid && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule
